sram_controller: RTL and testbench

- Sits downstream of the MEM stage and replaces the single-cycle data memory with an off-chip 16-bit asynchronous SRAM (DE2-style).
- Converts one 32-bit word load/store into two 16-bit SRAM accesses, then pads the access to a fixed latency.
- Drops `ready` while busy; the top level feeds `~ready` into the pipeline `freeze`.

---
 rtl/sram_controller.sv | 156 +++++++++++++++
 tb/tb_sram_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: replaces the single-cycle data memory with an off-chip
// 16-bit asynchronous SRAM. Each 32-bit word access is split into two
// halfword SRAM cycles (low half, then high half). The access is then padded
// to a fixed ACCESS_CYCLES latency, and ready is held low while busy.
//
// Ports:
//   clk, rst            pipeline clock, asynchronous active-low reset
//   rd_en, wr_en        load / store request from MEM stage (held while frozen)
//   address, writeData  byte address and store data from MEM stage
//   readData            load result, valid while ready=1 after a read
//   ready               0 = freeze the pipeline
//   SRAM_*              SRAM data bus, halfword address and active-low strobes
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 6,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WORD_W   = 17;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CNT_W-1:0]  cnt;
    logic              is_rd;
    logic [15:0]       wdata_hi;
    logic [WORD_W-1:0] word_q;
    logic [15:0]       dq_out;
    logic              dq_oe;
    logic [31:0]       off;
    logic              req;
    logic              unused_off;

    // Strobes the SRAM does not need to toggle.
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // Bus is driven only during the two halfword write cycles.
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // Byte offset into the SRAM window; bits [18:2] select the 32-bit word.
    assign off        = address - BASE_ADDR;
    assign unused_off = ^{off[31:19], off[1:0]};
    assign req        = rd_en | wr_en;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ready decode.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = ~req;
                if (req) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == LAST_CNT) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                ready      = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // SRAM cycle sequencing and read capture. Address, strobe and bus drive
    // are registered one edge ahead so each halfword cycle sees stable values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            is_rd     <= 1'b0;
            wdata_hi  <= '0;
            word_q    <= '0;
            readData  <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cnt       <= '0;
                        is_rd     <= rd_en;
                        wdata_hi  <= writeData[31:16];
                        word_q    <= off[18:2];
                        SRAM_ADDR <= {off[18:2], 1'b0};
                        // A read wins when both requests are present.
                        if (!rd_en) begin
                            SRAM_WE_N <= 1'b0;
                            dq_out    <= writeData[15:0];
                            dq_oe     <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(0)) begin
                        SRAM_ADDR <= {word_q, 1'b1};
                        if (is_rd) begin
                            readData[15:0] <= SRAM_DQ;
                        end else begin
                            dq_out <= wdata_hi;
                        end
                    end else if (cnt == CNT_W'(1)) begin
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (is_rd) begin
                            readData[31:16] <= SRAM_DQ;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: behavioural async SRAM model, table of
// word accesses with a scoreboard of expected load data, plus hand-written
// sequences for idle, mid-write reset and back-to-back accesses.
module tb_sram_controller;

    localparam int unsigned AC = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;

    int n_tests = 0;
    int n_fail  = 0;

    // SRAM model: drives the bus only when enabled by the bench and WE_N is high.
    logic [15:0] mem [0:262143];
    logic        model_en = 1'b0;

    assign sram_dq = (model_en && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr] <= sram_dq;
        end
    end

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(32'd1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .writeData (writeData),
        .readData  (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Undriven bus: Z in four-state simulators, 0 in two-state ones.
    function automatic logic dq_released(input logic [15:0] v);
        return $isunknown(v) || (v == 16'h0000);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One complete access: request raised in cycle T (caller is just after an
    // edge), checked every cycle through DONE at T+AC, dropped at T+AC+1.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [17:0] lo, input logic [31:0] exp);
        int          we_cnt;
        logic        is_read;
        logic [31:0] rd_before;
        logic [31:0] exp_rd;
        we_cnt    = 0;
        is_read   = rd;
        rd_before = read_data;
        model_en  = is_read;
        rd_en     = rd;
        wr_en     = wr;
        address   = addr;
        writeData = wdata;
        if (is_read) sb.push_back(exp);

        @(negedge clk);
        check({name, "/req_ready"}, 32'(ready), 32'd0);
        if (!sram_we_n) we_cnt++;

        for (int k = 1; k < int'(AC); k++) begin
            @(negedge clk);
            if (!sram_we_n) we_cnt++;
            check({name, "/busy_ready"}, 32'(ready), 32'd0);
            if (k == 1) begin
                check({name, "/addr_lo"}, 32'(sram_addr), 32'(lo));
                if (!is_read) begin
                    check({name, "/we_lo"}, 32'(sram_we_n), 32'd0);
                    check({name, "/dq_lo"}, 32'(sram_dq), 32'(wdata[15:0]));
                end
                // Inputs wander during the freeze; only latched values count.
                address   = $urandom;
                writeData = $urandom;
            end else if (k == 2) begin
                check({name, "/addr_hi"}, 32'(sram_addr), 32'(lo | 18'd1));
                if (!is_read) begin
                    check({name, "/we_hi"}, 32'(sram_we_n), 32'd0);
                    check({name, "/dq_hi"}, 32'(sram_dq), 32'(wdata[31:16]));
                end
            end else begin
                check({name, "/we_pad"}, 32'(sram_we_n), 32'd1);
                check({name, "/addr_pad"}, 32'(sram_addr), 32'(lo | 18'd1));
                if (!is_read) check({name, "/dq_pad_z"}, 32'(dq_released(sram_dq)), 32'd1);
            end
        end

        @(negedge clk);
        if (!sram_we_n) we_cnt++;
        check({name, "/done_ready"}, 32'(ready), 32'd1);
        check({name, "/we_pulses"}, 32'(we_cnt), is_read ? 32'd0 : 32'd2);
        if (is_read) begin
            exp_rd = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
            check({name, "/rdata"}, read_data, exp_rd);
        end else begin
            check({name, "/rdata_kept"}, read_data, rd_before);
        end

        sync();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;

        vecs[0] = '{"st_1024",   1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0,       32'h0};
        vecs[1] = '{"ld_1024",   1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'hDEADBEEF};
        vecs[2] = '{"st_1028",   1'b0, 1'b1, 32'd1028, 32'h12345678, 18'd2,       32'h0};
        vecs[3] = '{"ld_1024b",  1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'hDEADBEEF};
        vecs[4] = '{"ld_1028",   1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,       32'h12345678};
        vecs[5] = '{"st_wrap",   1'b0, 1'b1, 32'd0,    32'hCAFEF00D, 18'h3FE00,   32'h0};
        vecs[6] = '{"ld_wrap",   1'b1, 1'b0, 32'd0,    32'h0,        18'h3FE00,   32'hCAFEF00D};
        vecs[7] = '{"ld_unalgn", 1'b1, 1'b0, 32'd1030, 32'h0,        18'd2,       32'h12345678};
        vecs[8] = '{"rd_and_wr", 1'b1, 1'b1, 32'd1024, 32'h11112222, 18'd0,       32'hDEADBEEF};
        vecs[9] = '{"ld_after",  1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'hDEADBEEF};

        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = '0;
        repeat (2) @(negedge clk);
        check("rst/ready", 32'(ready), 32'd1);
        check("rst/we_n", 32'(sram_we_n), 32'd1);
        check("rst/addr", 32'(sram_addr), 32'd0);
        check("rst/rdata", read_data, 32'd0);
        check("rst/dq_z", 32'(dq_released(sram_dq)), 32'd1);
        check("rst/tied", 32'({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}), 32'd0);
        sync();
        rst = 1'b1;
        sync();

        // Table of accesses, each followed by an idle-cycle check.
        for (int i = 0; i < 10; i++) begin
            access(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                   vecs[i].wdata, vecs[i].lo, vecs[i].exp);
            @(negedge clk);
            check({vecs[i].name, "/idle_ready"}, 32'(ready), 32'd1);
            sync();
        end

        // Ten idle cycles with the SRAM model silent.
        model_en = 1'b0;
        held = read_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle/ready", 32'(ready), 32'd1);
            check("idle/we_n", 32'(sram_we_n), 32'd1);
            check("idle/dq_z", 32'(dq_released(sram_dq)), 32'd1);
            check("idle/rdata", read_data, held);
        end
        sync();

        // Reset while the high-half write strobe is active.
        wr_en = 1'b1; address = 32'd1032; writeData = 32'hAAAA5555;
        repeat (3) @(negedge clk);
        check("mid_rst/pre_we", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst/we_n", 32'(sram_we_n), 32'd1);
        check("mid_rst/dq_z", 32'(dq_released(sram_dq)), 32'd1);
        check("mid_rst/rdata", read_data, 32'd0);
        check("mid_rst/addr", 32'(sram_addr), 32'd0);
        wr_en = 1'b0;
        #1;
        check("mid_rst/ready", 32'(ready), 32'd1);
        sync();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst/ready", 32'(ready), 32'd1);
        sync();
        access("ld_post_rst", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
        @(negedge clk);
        check("ld_post_rst/idle_ready", 32'(ready), 32'd1);
        sync();

        // Back-to-back load then store: second request held from T+7.
        access("b2b_ld", 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'h12345678);
        access("b2b_st", 1'b0, 1'b1, 32'd1036, 32'h0BADCAFE, 18'd6, 32'h0);
        access("b2b_ld2", 1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 32'h0BADCAFE);
        @(negedge clk);
        check("b2b/idle_ready", 32'(ready), 32'd1);
        check("sb/empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
